// File: rtl/alu_result_fifo.sv
// ---------------------------------------------------------------------------
// alu_result_fifo
//   Output stage behind the ALU. Each accepted cycle captures one ALU result
//   together with its 4-bit flag word into a first-word-fall-through FIFO.
//   The head entry is offered to the consumer over a valid/ready handshake.
//   Sticky status accumulates the flags of every accepted entry until it is
//   cleared.
//
//   Optional feature (macro ALU_FIFO_ERR_DROP_EN):
//     Entries whose ERR flag (i_flag[0]) is set are still accepted on the
//     handshake but are not stored. Each one increments a saturating drop
//     counter. Without the macro, ERR entries are stored normally and
//     o_drop_cnt is tied to zero.
//
// Ports
//   i_clk, i_rstn      clock (rising edge), asynchronous active-low reset
//   i_result, i_flag   producer data {flag, result}; i_flag = {OVF,POS,NEG,ERR}
//   i_valid / o_ready  producer handshake (o_ready = !o_full)
//   o_data, o_flag     head entry, forced to zero while empty
//   o_valid / i_ready  consumer handshake (o_valid = !o_empty)
//   o_count            occupancy 0..DEPTH
//   o_full, o_empty    occupancy status
//   o_sticky_flag      OR of flags of accepted entries since the last clear
//   i_clr_sticky       synchronous clear of o_sticky_flag
//   o_drop_cnt         number of dropped ERR entries (saturating)
// ---------------------------------------------------------------------------
module alu_result_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic [WIDTH-1:0]         i_result,
    input  logic [3:0]               i_flag,
    input  logic                     i_valid,
    output logic                     o_ready,
    output logic [WIDTH-1:0]         o_data,
    output logic [3:0]               o_flag,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [3:0]               o_sticky_flag,
    input  logic                     i_clr_sticky,
    output logic [CNT_W-1:0]         o_drop_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = WIDTH + 4;

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [3:0]    sticky_q, sticky_d;

    logic          full, empty;
    logic          push, pop, drop_en, wr_en;
    logic [EW-1:0] head;

    // All status outputs derive from the single count register.
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Handshakes are gated by status, so push-when-full and pop-when-empty
    // cannot happen; no bypass path from pop to o_ready.
    assign push  = i_valid & ~full;
    assign pop   = i_ready & ~empty;
    assign wr_en = push & ~drop_en;

`ifdef ALU_FIFO_ERR_DROP_EN
    logic [CNT_W-1:0] drop_q, drop_d;

    assign drop_en = push & i_flag[0];

    always_comb begin
        drop_d = drop_q;
        if (drop_en && (drop_q != {CNT_W{1'b1}})) begin
            drop_d = drop_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign o_drop_cnt = drop_q;
`else
    assign drop_en    = 1'b0;
    assign o_drop_cnt = '0;
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({wr_en, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // A flag set by an entry accepted this cycle survives a same-cycle clear.
        sticky_d = (i_clr_sticky ? 4'b0000 : sticky_q) | (push ? i_flag : 4'b0000);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            sticky_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            sticky_q <= sticky_d;
        end
    end

    // Storage needs no reset: it is only observed through the empty gate.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {i_flag, i_result};
        end
    end

    assign head          = mem_q[rd_ptr_q];
    assign o_data        = empty ? '0 : head[WIDTH-1:0];
    assign o_flag        = empty ? 4'b0000 : head[EW-1:WIDTH];
    assign o_valid       = ~empty;
    assign o_ready       = ~full;
    assign o_full        = full;
    assign o_empty       = empty;
    assign o_count       = count_q;
    assign o_sticky_flag = sticky_q;

endmodule

// File: tb/tb_alu_result_fifo.sv
module tb_alu_result_fifo;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int SW    = CW + 4 + 4 + WIDTH;

    logic               i_clk = 1'b0;
    logic               i_rstn = 1'b0;
    logic [WIDTH-1:0]   i_result = '0;
    logic [3:0]         i_flag = '0;
    logic               i_valid = 1'b0;
    logic               o_ready;
    logic [WIDTH-1:0]   o_data;
    logic [3:0]         o_flag;
    logic               o_valid;
    logic               i_ready = 1'b0;
    logic [CW-1:0]      o_count;
    logic               o_full;
    logic               o_empty;
    logic [3:0]         o_sticky_flag;
    logic               i_clr_sticky = 1'b0;
    logic [CNT_W-1:0]   o_drop_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model: queue of {flag,result}, sticky word, drop count.
    logic [WIDTH+3:0]   mq[$];
    logic [3:0]         m_sticky = '0;
    int                 m_drop = 0;

    alu_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_result(i_result), .i_flag(i_flag),
        .i_valid(i_valid), .o_ready(o_ready), .o_data(o_data), .o_flag(o_flag),
        .o_valid(o_valid), .i_ready(i_ready), .o_count(o_count), .o_full(o_full),
        .o_empty(o_empty), .o_sticky_flag(o_sticky_flag), .i_clr_sticky(i_clr_sticky),
        .o_drop_cnt(o_drop_cnt)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    function automatic logic [SW-1:0] exp_status();
        logic [CW-1:0]    c;
        logic [WIDTH+3:0] h;
        c = CW'(mq.size());
        h = (mq.size() > 0) ? mq[0] : '0;
        return {c, (mq.size() == DEPTH), (mq.size() == 0), (mq.size() < DEPTH),
                (mq.size() > 0), h[WIDTH+3:WIDTH], h[WIDTH-1:0]};
    endfunction

    function automatic logic [SW-1:0] dut_status();
        return {o_count, o_full, o_empty, o_ready, o_valid, o_flag, o_data};
    endfunction

    function automatic logic [CNT_W-1:0] exp_drop();
        return CNT_W'(m_drop);
    endfunction

    // Advance one clock: the model applies the same handshake rules to the
    // inputs currently driven, then inputs may change 1 time unit later.
    task automatic tick();
        bit push, pop;
        push = i_rstn && i_valid && (mq.size() < DEPTH);
        pop  = i_rstn && i_ready && (mq.size() > 0);
        @(posedge i_clk);
        if (i_rstn) begin
            if (pop) void'(mq.pop_front());
            m_sticky = (i_clr_sticky ? 4'b0000 : m_sticky) | (push ? i_flag : 4'b0000);
`ifdef ALU_FIFO_ERR_DROP_EN
            if (push && i_flag[0]) begin
                if (m_drop < (1 << CNT_W) - 1) m_drop++;
            end else if (push) begin
                mq.push_back({i_flag, i_result});
            end
`else
            if (push) mq.push_back({i_flag, i_result});
`endif
        end
        #1;
    endtask

    task automatic drive(input bit v, input logic [WIDTH-1:0] d, input logic [3:0] f,
                         input bit r, input bit clr);
        i_valid = v; i_result = d; i_flag = f; i_ready = r; i_clr_sticky = clr;
    endtask

    task automatic drain();
        drive(0, '0, '0, 1, 0);
        for (int i = 0; i < 2 * DEPTH && mq.size() > 0; i++) tick();
        drive(0, '0, '0, 0, 0);
    endtask

    task automatic test_reset();
        i_rstn = 1'b0;
        mq.delete(); m_sticky = '0; m_drop = 0;
        drive(1, 4'hA, 4'b0110, 0, 0);
        repeat (3) tick();
        total++; if (o_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", o_empty); end
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
        total++; if (o_count !== '0) begin bad++; $display("FAIL reset_count got=%0d exp=0", o_count); end
        total++; if ({o_data, o_flag, o_valid, o_full} !== '0) begin
            bad++; $display("FAIL reset_head data=%h flag=%b valid=%b full=%b exp all 0", o_data, o_flag, o_valid, o_full);
        end
        total++; if ({o_sticky_flag, o_drop_cnt} !== '0) begin
            bad++; $display("FAIL reset_status sticky=%b drop=%0d exp 0", o_sticky_flag, o_drop_cnt);
        end
        drive(0, '0, '0, 0, 0);
        #3 i_rstn = 1'b1;
        tick();
    endtask

    task automatic test_single_pass();
        drive(1, 4'b0010, 4'b0100, 0, 0);
        tick();
        drive(0, '0, '0, 0, 0);
        total++; if ({o_valid, o_data, o_flag} !== {1'b1, 4'b0010, 4'b0100}) begin
            bad++; $display("FAIL single_head valid=%b data=%b flag=%b exp 1 0010 0100", o_valid, o_data, o_flag);
        end
        drive(0, '0, '0, 1, 0);
        tick();
        drive(0, '0, '0, 0, 0);
        total++; if (o_empty !== 1'b1) begin bad++; $display("FAIL single_pop_empty got=%b exp=1", o_empty); end
        total++; if (o_sticky_flag !== 4'b0100) begin bad++; $display("FAIL single_sticky got=%b exp=0100", o_sticky_flag); end
    endtask

    task automatic test_fill_wrap();
        logic [3:0] d;
        for (int i = 1; i <= 5; i++) begin
            d = 4'(i);
            drive(1, d, 4'b0100, 0, 0);
            tick();
            total++; if (o_count !== CW'((i > 4) ? 4 : i)) begin
                bad++; $display("FAIL fill_count push=%0d got=%0d exp=%0d", i, o_count, (i > 4) ? 4 : i);
            end
        end
        total++; if ({o_full, o_ready, o_data} !== {1'b1, 1'b0, 4'd1}) begin
            bad++; $display("FAIL fill_full full=%b ready=%b head=%0d exp 1 0 1", o_full, o_ready, o_data);
        end
        // Full with i_ready=1: pop only, the offered entry is refused.
        drive(1, 4'd9, 4'b0100, 1, 0);
        tick();
        total++; if ({o_count, o_data} !== {CW'(3), 4'd2}) begin
            bad++; $display("FAIL full_pop_only count=%0d head=%0d exp 3 2", o_count, o_data);
        end
        for (int i = 2; i <= 4; i++) begin
            drive(0, '0, '0, 1, 0);
            total++; if (o_data !== 4'(i)) begin bad++; $display("FAIL drain_order got=%0d exp=%0d", o_data, i); end
            tick();
        end
        total++; if (o_empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b exp=1", o_empty); end
        drive(1, 4'd6, 4'b0100, 0, 0); tick();
        drive(1, 4'd7, 4'b0100, 0, 0); tick();
        drive(0, '0, '0, 1, 0);
        total++; if (o_data !== 4'd6) begin bad++; $display("FAIL wrap_first got=%0d exp=6", o_data); end
        tick();
        total++; if (o_data !== 4'd7) begin bad++; $display("FAIL wrap_second got=%0d exp=7", o_data); end
        tick();
        drive(0, '0, '0, 0, 0);
        total++; if (o_count !== '0) begin bad++; $display("FAIL wrap_empty count=%0d exp=0", o_count); end
    endtask

    task automatic test_simultaneous();
        drive(1, 4'hA, 4'b0010, 0, 0); tick();
        drive(1, 4'hB, 4'b0010, 0, 0); tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 4'(4'hC + i), 4'b0010, 1, 0);
            tick();
            total++; if ({o_count, o_data} !== {CW'(2), 4'(4'hB + i)}) begin
                bad++; $display("FAIL simul_cycle%0d count=%0d head=%h exp 2 %h", i, o_count, o_data, 4'(4'hB + i));
            end
        end
        drive(0, '0, '0, 1, 0);
        tick();
        total++; if (o_data !== 4'hE) begin bad++; $display("FAIL simul_tail got=%h exp=E", o_data); end
        drain();
    endtask

    task automatic test_sticky_clear();
        drive(0, '0, '0, 0, 1); tick();
        total++; if (o_sticky_flag !== 4'b0000) begin bad++; $display("FAIL sticky_clr0 got=%b exp=0000", o_sticky_flag); end
        drive(1, 4'h3, 4'b1000, 0, 1); tick();
        total++; if (o_sticky_flag !== 4'b1000) begin bad++; $display("FAIL sticky_set_wins got=%b exp=1000", o_sticky_flag); end
        drive(0, '0, '0, 0, 1); tick();
        total++; if (o_sticky_flag !== 4'b0000) begin bad++; $display("FAIL sticky_clear got=%b exp=0000", o_sticky_flag); end
        drain();
    endtask

    task automatic test_err_entry();
        drive(1, 4'hF, 4'b0001, 0, 0); tick();
        drive(0, '0, '0, 0, 0);
`ifdef ALU_FIFO_ERR_DROP_EN
        total++; if ({o_count, o_drop_cnt, o_sticky_flag[0]} !== {CW'(0), CNT_W'(1), 1'b1}) begin
            bad++; $display("FAIL err_drop count=%0d drop=%0d sticky0=%b exp 0 1 1", o_count, o_drop_cnt, o_sticky_flag[0]);
        end
        for (int i = 0; i < 260; i++) begin
            drive(1, 4'h1, 4'b0001, 0, 0); tick();
        end
        drive(0, '0, '0, 0, 0);
        total++; if (o_drop_cnt !== {CNT_W{1'b1}}) begin bad++; $display("FAIL err_drop_sat got=%0d exp=255", o_drop_cnt); end
`else
        total++; if ({o_count, o_data, o_flag, o_drop_cnt} !== {CW'(1), 4'hF, 4'b0001, CNT_W'(0)}) begin
            bad++; $display("FAIL err_store count=%0d data=%h flag=%b drop=%0d exp 1 F 0001 0", o_count, o_data, o_flag, o_drop_cnt);
        end
`endif
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 99) < 60, 4'($urandom), 4'($urandom), $urandom_range(0, 99) < 45,
                  $urandom_range(0, 99) < 8);
            tick();
            total++; if (dut_status() !== exp_status()) begin
                bad++; $display("FAIL random_status cyc=%0d got=%h exp=%h", i, dut_status(), exp_status());
            end
            total++; if ({o_sticky_flag, o_drop_cnt} !== {m_sticky, exp_drop()}) begin
                bad++; $display("FAIL random_sticky cyc=%0d sticky=%b drop=%0d exp %b %0d", i, o_sticky_flag, o_drop_cnt, m_sticky, m_drop);
            end
        end
        drive(0, '0, '0, 0, 0);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            drive(1, 4'(i + 3), 4'b0100, 0, 0); tick();
        end
        #2 i_rstn = 1'b0;
        mq.delete(); m_sticky = '0; m_drop = 0;
        #1;
        total++; if ({o_empty, o_count, o_sticky_flag} !== {1'b1, CW'(0), 4'b0000}) begin
            bad++; $display("FAIL midreset empty=%b count=%0d sticky=%b exp 1 0 0000", o_empty, o_count, o_sticky_flag);
        end
        tick();
        drive(0, '0, '0, 0, 0);
        #2 i_rstn = 1'b1;
        tick();
        drive(1, 4'h5, 4'b0010, 0, 0); tick();
        drive(0, '0, '0, 0, 0);
        total++; if ({o_count, o_data, o_flag} !== {CW'(1), 4'h5, 4'b0010}) begin
            bad++; $display("FAIL post_reset_push count=%0d data=%h flag=%b exp 1 5 0010", o_count, o_data, o_flag);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_fill_wrap();
        test_simultaneous();
        test_sticky_clear();
        test_err_entry();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
